// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared, registered ALU.
// Each legal operation takes a four-cycle IDLE/EXEC/CAPT/RESP round trip; op 7 is answered at once.
module alu_arbiter #(
   parameter int unsigned FIRST = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   input  logic [2:0]  op0,
   input  logic [2:0]  op1,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic [31:0] result,
   output logic        zero,
   output logic        err,
   output logic        done0,
   output logic        done1,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

   localparam logic       LastRst = (FIRST == 0) ? 1'b1 : 1'b0;
   localparam logic [2:0] OpIllegal = 3'd7;

   state_e      state_q, state_d;
   logic [31:0] in1_q, in1_d, in2_q, in2_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        err_q, err_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic        busy_q, busy_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;

   logic        grant;
   logic [31:0] sel_a, sel_b;
   logic [2:0]  sel_op;

   // Contested requests go to whoever was not served last; otherwise to the sole requester.
   always_comb begin
      if (req0 && req1) begin
         grant = ~last_q;
      end else begin
         grant = req1;
      end
      sel_a  = grant ? a1 : a0;
      sel_b  = grant ? b1 : b0;
      sel_op = grant ? op1 : op0;
   end

   always_comb begin
      state_d  = state_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      op_d     = op_q;
      result_d = result_q;
      zero_d   = zero_q;
      err_d    = err_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      owner_d  = owner_q;
      last_d   = last_q;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               owner_d = grant;
               if (sel_op == OpIllegal) begin
                  // ALU registers are left alone; the requester is answered immediately.
                  result_d = 32'd0;
                  zero_d   = 1'b0;
                  err_d    = 1'b1;
                  done0_d  = ~grant;
                  done1_d  = grant;
                  state_d  = StResp;
               end else begin
                  in1_d   = sel_a;
                  in2_d   = sel_b;
                  op_d    = sel_op;
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            state_d = StCapt;
         end
         StCapt: begin
            result_d = alu_out;
            zero_d   = alu_zero;
            err_d    = 1'b0;
            done0_d  = ~owner_q;
            done1_d  = owner_q;
            last_d   = owner_q;
            state_d  = StResp;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         in1_q    <= 32'd0;
         in2_q    <= 32'd0;
         op_q     <= 3'd0;
         result_q <= 32'd0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         owner_q  <= 1'b0;
         last_q   <= LastRst;
      end else begin
         state_q  <= state_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
      end
   end

   assign alu_in1 = in1_q;
   assign alu_in2 = in2_q;
   assign alu_op  = op_q;
   assign result  = result_q;
   assign zero    = zero_q;
   assign err     = err_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model (countdown per operation) checked
// every cycle, plus literal expectations for the headline scenarios.
module tb_alu_arbiter;

   localparam int unsigned FIRST = 0;

   logic        clk, reset, req0, req1;
   logic [31:0] a0, b0, a1, b1;
   logic [2:0]  op0, op1;
   logic [31:0] alu_in1, alu_in2, alu_out, result;
   logic [2:0]  alu_op;
   logic        alu_zero, zero, err, done0, done1, busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_arbiter #(.FIRST(FIRST)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .result(result), .zero(zero), .err(err),
      .done0(done0), .done1(done1), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a << b[4:0];
         3'd5:    return a >> b[4:0];
         3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Shared ALU: result and equality flag registered one clock after sampling.
   always @(posedge clk) begin
      alu_out  <= alu_fn(alu_in1, alu_in2, alu_op);
      alu_zero <= (alu_in1 == alu_in2);
   end

   // Model: cycles left in the current operation; done is the final one.
   int          m_cnt;
   logic        m_owner, m_last, m_valid = 1'b0;
   logic [31:0] m_in1, m_in2, m_res, m_pres;
   logic [2:0]  m_op;
   logic        m_zero, m_pzero, m_err;

   always @(posedge clk) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      if (reset) begin
         m_cnt = 0; m_owner = 1'b0; m_last = (FIRST == 0) ? 1'b1 : 1'b0;
         m_in1 = 0; m_in2 = 0; m_op = 0; m_res = 0; m_zero = 0; m_err = 0;
         m_valid = 1'b1;
      end else if (m_cnt == 0) begin
         if (req0 || req1) begin
            m_owner = (req0 && req1) ? ~m_last : req1;
            a  = m_owner ? a1 : a0;
            b  = m_owner ? b1 : b0;
            op = m_owner ? op1 : op0;
            if (op == 3'd7) begin
               m_res = 0; m_zero = 0; m_err = 1; m_cnt = 1;
            end else begin
               m_in1 = a; m_in2 = b; m_op = op;
               m_pres = alu_fn(a, b, op); m_pzero = (a == b); m_cnt = 3;
            end
         end
      end else begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 1) begin
            m_res = m_pres; m_zero = m_pzero; m_err = 0; m_last = m_owner;
         end
      end
   end

   task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
      else pass_cnt++;
   endtask

   // Advance one cycle and compare every output with the model on the falling edge.
   task automatic tick();
      logic [103:0] act, exp;
      @(negedge clk);
      if (m_valid) begin
         exp = {m_cnt != 0, (m_cnt == 1) && !m_owner, (m_cnt == 1) && m_owner, m_err, m_zero,
                m_res, m_in1, m_in2, m_op};
         act = {busy, done0, done1, err, zero, result, alu_in1, alu_in2, alu_op};
         check("cycle_model", act, exp);
         check("done_exclusive", {103'd0, done0 & done1}, 104'd0);
      end
   endtask

   task automatic wait_done(input logic who, output int cyc);
      cyc = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if ((who ? done1 : done0) === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   initial begin
      int cyc;
      int grants[4];
      int n;
      reset = 1'b1; req0 = 0; req1 = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
      repeat (2) tick();
      check("reset_outputs", {66'd0, busy, done0, done1, err, zero, result},
            {66'd0, 5'd0, 32'd0});
      check("reset_alu_regs", {37'd0, alu_in1, alu_in2, alu_op}, 104'd0);
      reset = 1'b0;

      // add 10+5 by requester 0
      a0 = 10; b0 = 5; op0 = 0; req0 = 1;
      wait_done(1'b0, cyc);
      check("add_latency", cyc, 3);
      check("add_result", {result, zero, err, done1}, {32'd15, 3'b000});
      req0 = 0;
      repeat (2) tick();

      // simultaneous after reset: requester 0 first
      reset = 1; tick(); reset = 0;
      a0 = 10; b0 = 5; op0 = 1; req0 = 1;
      a1 = 1;  b1 = 5; op1 = 6; req1 = 1;
      wait_done(1'b0, cyc);
      check("rr_first_latency", cyc, 3);
      check("rr_first_result", result, 32'd5);
      req0 = 0;
      wait_done(1'b1, cyc);
      check("rr_second_gap", cyc, 4);
      check("rr_second_result", result, 32'd1);
      req1 = 0;
      tick();

      // both held high: grants alternate
      a0 = 1; b0 = 2; op0 = 0; a1 = 7; b1 = 3; op1 = 1;
      req0 = 1; req1 = 1; n = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (done0 === 1'b1 && n < 4) begin grants[n] = 0; n++; end
         if (done1 === 1'b1 && n < 4) begin grants[n] = 1; n++; end
      end
      req0 = 0; req1 = 0;
      check("alt_count", n, 4);
      for (int i = 0; i < 4; i++) check("alt_order", grants[i], i % 2);
      repeat (2) tick();

      // and 5&5, operand change and req drop after grant
      a0 = 5; b0 = 5; op0 = 2; req0 = 1;
      tick();
      a0 = 99; req0 = 0;
      wait_done(1'b0, cyc);
      check("and_latency", cyc, 2);
      check("and_result", {result, zero}, {32'd5, 1'b1});
      repeat (2) tick();

      // illegal op from requester 1
      a1 = 123; b1 = 456; op1 = 7; req1 = 1;
      wait_done(1'b1, cyc);
      check("ill_latency", cyc, 1);
      check("ill_flags", {result, zero, err}, {32'd0, 1'b0, 1'b1});
      check("ill_alu_unchanged", {alu_in1, alu_in2, alu_op}, {32'd5, 32'd5, 3'd2});
      req1 = 0;
      tick();
      check("ill_hold", {err, done1, busy}, 3'b100);

      // reset during EXEC
      a0 = 3; b0 = 3; op0 = 0; req0 = 1;
      tick();
      check("exec_busy", busy, 1'b1);
      reset = 1; req0 = 0;
      tick();
      check("rst_mid_op", {busy, done0, done1, result}, {3'b000, 32'd0});
      reset = 0;
      a0 = 1; b0 = 4; op0 = 4; req0 = 1;
      wait_done(1'b0, cyc);
      check("sll_latency", cyc, 3);
      check("sll_result", result, 32'd16);
      req0 = 0;
      repeat (2) tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FIRST, default 0, naming the requester (0 or 1) that wins the first simultaneous request after reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state; reset  in  1  synchronous active-high reset.
REQ-003 req0 / req1  in  1  request from requester 0 / 1, held high until its done pulse.
REQ-004 a0, b0 / a1, b1  in  32 each  operands of requester 0 / 1, stable while the matching req is high.
REQ-005 op0 / op1  in  3  operation code of requester 0 / 1: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt, 7 illegal.
REQ-006 alu_in1, alu_in2  out  32  registered operands driven to the shared ALU.
REQ-007 alu_op  out  3  registered opcode driven to the shared ALU.
REQ-008 alu_out  in  32  ALU result, registered inside the ALU one clock after it samples its inputs.
REQ-009 alu_zero  in  1  ALU operand-equality flag, with the same timing as alu_out.
REQ-010 result  out  32  captured result; valid while done0 or done1 is high.
REQ-011 zero  out  1  captured alu_zero; valid while done0 or done1 is high.
REQ-012 err  out  1  high with done when the served opcode was 7.
REQ-013 done0 / done1  out  1  one-cycle completion pulse to requester 0 / 1.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, EXEC, CAPT, RESP, with all outputs registered.
REQ-016 In IDLE with no request, the state SHALL remain IDLE and alu_in1, alu_in2, alu_op SHALL hold their values.
REQ-017 In IDLE with exactly one req high, that requester SHALL be granted.
REQ-018 In IDLE with both req high, the requester not served last SHALL be granted (round-robin); after reset the last-served marker SHALL equal 1-FIRST.
REQ-019 On a grant with op != 7, the block SHALL load alu_in1/alu_in2/alu_op from the granted a/b/op, record the owner, and go to EXEC.
REQ-020 On a grant with op == 7, the block SHALL leave the ALU registers unchanged, set result=0, zero=0, err=1, assert the owner's done, and go directly to RESP.
REQ-021 EXEC SHALL last one cycle (the ALU samples at the exiting edge), then go to CAPT.
REQ-022 At the edge leaving CAPT, the block SHALL latch result=alu_out, zero=alu_zero, err=0, assert the owner's done, update the last-served marker, and go to RESP.
REQ-023 In RESP, done SHALL be high for exactly one cycle; at the exiting edge done SHALL clear and the state SHALL return to IDLE.
REQ-024 A request first sampled at edge E0 SHALL have done high in the cycle between E2 and E3 for legal ops, and between E0 and E1 for op 7.
REQ-025 Throughput SHALL be one legal operation per 4 cycles.
REQ-026 A requester SHALL drop req at the edge ending its done cycle; req still high in IDLE SHALL be treated as a new request.
REQ-027 req or operand changes after the grant SHALL NOT affect the in-flight operation.
REQ-028 If req drops mid-operation, the operation SHALL still complete and done SHALL still pulse.
REQ-029 done0 and done1 SHALL never be high in the same cycle.
REQ-030 result, zero and err SHALL hold their values outside done cycles.

Reset
REQ-031 While reset is high at a rising edge, the block SHALL set state=IDLE, every output to 0 and last-served=1-FIRST, overriding any in-flight operation, with no done issued for it.
REQ-032 After reset deasserts, the first request SHALL be sampled at the first edge with reset low.

Verification
REQ-033 req0, a0=10, b0=5, op0=0 at E0 -> done0 high between E2 and E3, result=15, zero=0, err=0, done1=0.
REQ-034 After reset, req0 (10,5,op1) and req1 (1,5,op6) raised together -> done0 first with result=5, then done1 four cycles later with result=1.
REQ-035 req1 held high continuously with req0 high (FIRST=0) -> grants alternate 0,1,0,1; no requester is served twice in a row.
REQ-036 req0, a0=5, b0=5, op0=2 -> result=5, zero=1.
REQ-037 req1 with op1=7 -> done1 between E0 and E1, err=1, result=0, alu_in1/alu_in2/alu_op unchanged.
REQ-038 reset asserted while the state is EXEC -> next cycle busy=0, done0=done1=0, result=0; a subsequent req0 (1,4,op4) completes with result=16.
